// File: rtl/avl_frame_writer_if.sv
// Avalon-style memory-mapped bus between the frame writer (master) and the
// SDRAM controller (slave). Burst count is 8 bits wide, enough for bursts of up to 255 words.
interface i_avl_bus;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic        begin_burst_transfer;
  logic [7:0]  burst_count;
  logic        request_ready;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        resp_ready;

  modport master (
    output address, byte_en, write, write_data, read,
           begin_burst_transfer, burst_count, resp_ready,
    input  request_ready, read_data_valid, read_data
  );

  modport slave (
    input  address, byte_en, write, write_data, read,
           begin_burst_transfer, burst_count, resp_ready,
    output request_ready, read_data_valid, read_data
  );
endinterface

// File: rtl/avl_frame_writer.sv
// avl_frame_writer: packs RGB565 pixel pairs into 32-bit words, buffers them in
// a small FIFO and writes one frame to consecutive SDRAM words in fixed bursts.
// Optional feature macro: AVL_FRAME_WRITER_PINGPONG_EN (alternating frame
// buffers, adds the buf_sel output).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame in progress, waiting for frame_start
// S_WAIT  | frame active, waiting for enough FIFO words for next burst
// S_BURST | issuing write beats of the current burst
// S_DONE  | last beat accepted, frame_done pulse, back to S_IDLE
module avl_frame_writer #(
  parameter int          FIFO_DEPTH  = 16,
  parameter int          BURST_LEN   = 8,
  parameter int          FRAME_WORDS = 153600,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
  output logic        buf_sel,
`endif
  i_avl_bus.master    avl_m0
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int WW   = $clog2(FRAME_WORDS + 1);
  localparam int CW0  = (WW > CNTW) ? WW : CNTW;
  localparam int CW   = (CW0 > 8) ? CW0 : 8;
  localparam logic [WW-1:0] FW_W = WW'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   fifo_count;
  logic              half_valid;
  logic [15:0]       half_data;
  logic [WW-1:0]     packed_words;
  logic [WW-1:0]     word_idx;
  logic [31:0]       address_q;
  logic [31:0]       write_data_q;
  logic [31:0]       frame_base;
  logic              write_q;
  logic              bbt_q;
  logic [7:0]        burst_count_q;
  logic [7:0]        beat_left;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     beats;
  logic              start_fire;
  logic              pix_fire;
  logic              push;
  logic              pop;
  logic              frame_last;
  logic              unused_rd;

  assign start_fire = frame_start && (state == S_IDLE);
  assign pix_ready  = busy && (fifo_count != CNTW'(FIFO_DEPTH)) && (packed_words < FW_W);
  assign pix_fire   = pix_valid && pix_ready;
  assign push       = pix_fire && half_valid;
  // write_q is only ever high in S_BURST, so it qualifies the beat on its own
  assign pop        = write_q && avl_m0.request_ready;
  assign frame_last = (word_idx == FW_W - WW'(1));
  assign remaining  = CW'(FW_W) - CW'(word_idx);
  assign beats      = (remaining < CW'(BURST_LEN)) ? remaining : CW'(BURST_LEN);

`ifdef AVL_FRAME_WRITER_PINGPONG_EN
  logic buf_sel_q;

  assign frame_base = buf_sel_q ? (BASE_ADDR + 32'(4 * FRAME_WORDS)) : BASE_ADDR;
  assign buf_sel    = buf_sel_q;

  // Flip to the other buffer as the frame completes so idle shows the next one
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      buf_sel_q <= 1'b0;
    end else if (pop && (beat_left == 8'd1) && frame_last) begin
      buf_sel_q <= ~buf_sel_q;
    end
  end
`else
  assign frame_base = BASE_ADDR;
`endif

  // Word FIFO payload; contents need no reset since pointers gate validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_data, half_data};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count as is
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (start_fire) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
    end
  end

  // Pixel packer: first pixel of a pair is the low half, second completes the word
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      half_valid   <= 1'b0;
      half_data    <= '0;
      packed_words <= '0;
    end else if (start_fire) begin
      half_valid   <= 1'b0;
      half_data    <= '0;
      packed_words <= '0;
    end else if (pix_fire) begin
      if (half_valid) begin
        half_valid   <= 1'b0;
        packed_words <= packed_words + WW'(1);
      end else begin
        half_valid <= 1'b1;
        half_data  <= pix_data;
      end
    end
  end

  // Frame sequencer with registered bus outputs; bus holds while request_ready is low
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      write_q       <= 1'b0;
      bbt_q         <= 1'b0;
      burst_count_q <= '0;
      beat_left     <= '0;
      address_q     <= BASE_ADDR;
      write_data_q  <= '0;
      word_idx      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            busy      <= 1'b1;
            word_idx  <= '0;
            address_q <= frame_base;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (CW'(fifo_count) >= beats) begin
            write_q       <= 1'b1;
            bbt_q         <= 1'b1;
            burst_count_q <= 8'(beats);
            beat_left     <= 8'(beats);
            write_data_q  <= fifo_mem[rd_ptr];
            state         <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop) begin
            word_idx  <= word_idx + WW'(1);
            address_q <= address_q + 32'd4;
            bbt_q     <= 1'b0;
            if (beat_left == 8'd1) begin
              write_q <= 1'b0;
              if (frame_last) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              // Remaining beats guarantee the next entry is already written
              beat_left    <= beat_left - 8'd1;
              write_data_q <= fifo_mem[rd_ptr + AW'(1)];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign avl_m0.address              = address_q;
  assign avl_m0.byte_en              = 4'hF;
  assign avl_m0.write                = write_q;
  assign avl_m0.write_data           = write_data_q;
  assign avl_m0.read                 = 1'b0;
  assign avl_m0.begin_burst_transfer = bbt_q;
  assign avl_m0.burst_count          = burst_count_q;
  assign avl_m0.resp_ready           = 1'b1;

  // The write-only master has no use for the read return path
  assign unused_rd = ^{avl_m0.read_data, avl_m0.read_data_valid};

endmodule

// File: tb/tb_avl_frame_writer.sv
// Testbench for avl_frame_writer: random pixel/request_ready traffic, frame
// contents and burst framing compared against a pixel-stream reference model.
module tb_avl_frame_writer;

  localparam int          DEPTH = 16;
  localparam int          BL    = 8;
  localparam int          FW    = 20;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rest;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
  logic        buf_sel;
`endif

  i_avl_bus bus();

  avl_frame_writer #(
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk        (clk),
    .rest       (rest),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
    .buf_sel    (buf_sel),
`endif
    .avl_m0     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model state
  logic [15:0] pix_log [$];
  int          beat_k;
  int          last_beat_cyc;
  int          done_cnt = 0;
  bit          frame_seen;
  bit          bsel_m;
  logic [31:0] fbase_m;
  bit          last_acc;
  bit          gap_next;
  bit          stall_prev;
  logic [31:0] h_addr, h_data;
  logic [7:0]  h_bc;
  logic        h_bbt;
  int          rr_mode;
  bit          stop_pix;
  logic [15:0] pix_ctr;
  int          mk, ms, mlen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.request_ready = 1'b1;
      1:       bus.request_ready = ($urandom_range(99) < 60);
      default: bus.request_ready = 1'b0;
    endcase
  end

  // Monitor/scoreboard: sampled on the falling edge, describing the coming rising edge
  always @(negedge clk) begin
    last_acc = pix_valid && pix_ready;
    if (rest) begin
      if (gap_next) begin
        chk("burst_gap_write", bus.write, 0);
        gap_next = 0;
      end
      if (stall_prev) begin
        chk("hold_write", bus.write, 1);
        chk("hold_addr", bus.address, h_addr);
        chk("hold_data", bus.write_data, h_data);
        chk("hold_bcount", bus.burst_count, h_bc);
        chk("hold_bbt", bus.begin_burst_transfer, h_bbt);
      end
      stall_prev = bus.write && !bus.request_ready;
      h_addr = bus.address;
      h_data = bus.write_data;
      h_bc   = bus.burst_count;
      h_bbt  = bus.begin_burst_transfer;
      if (bus.write && bus.request_ready) begin
        mk   = beat_k;
        ms   = (mk / BL) * BL;
        mlen = (FW - ms < BL) ? FW - ms : BL;
        chk("beat_addr", bus.address, fbase_m + 32'(4 * mk));
        if (2 * mk + 1 < pix_log.size())
          chk("beat_data", bus.write_data, {pix_log[2*mk+1], pix_log[2*mk]});
        else
          chk("beat_data_early", pix_log.size(), 2 * mk + 2);
        chk("beat_bcount", bus.burst_count, mlen);
        chk("beat_bbt", bus.begin_burst_transfer, (mk == ms) ? 1 : 0);
        beat_k++;
        last_beat_cyc = cyc;
        if (mk - ms + 1 == mlen) gap_next = 1;
      end
      if (pix_valid && pix_ready) pix_log.push_back(pix_data);
      if (frame_done) begin
        chk("done_latency", cyc - last_beat_cyc, 1);
        chk("done_beats", beat_k, FW);
        chk("done_busy", busy, 0);
        done_cnt++;
        frame_seen = 1;
        if (PP) bsel_m = ~bsel_m;
      end
    end
  end

  task automatic start_frame();
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
    chk("buf_sel_idle", buf_sel, bsel_m);
`endif
    fbase_m    = BASE + (bsel_m ? 32'(4 * FW) : 32'd0);
    beat_k     = 0;
    pix_log.delete();
    frame_seen = 0;
    stop_pix   = 0;
    pix_ctr    = 16'h0001;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drive_pix(input int pct, input bit inc, input int max_cyc);
    int n = 0;
    while (!frame_seen && !stop_pix && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
      if (!pix_valid || last_acc) begin
        pix_valid = ($urandom_range(99) < pct);
        if (inc) begin
          pix_data = pix_ctr;
          if (pix_valid) pix_ctr++;
        end else begin
          pix_data = 16'($urandom);
        end
      end
    end
    @(posedge clk); #1 pix_valid = 1'b0;
  endtask

  task automatic end_frame(input int exp_done);
    chk("frame_completed", frame_seen, 1);
    chk("pix_accepted", pix_log.size(), 2 * FW);
    chk("done_count", done_cnt, exp_done);
    repeat (3) @(posedge clk);
    #1 chk("idle_pix_ready", pix_ready, 0);
  endtask

  initial begin
    rest = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    bus.request_ready = 1'b1; bus.read_data_valid = 1'b0; bus.read_data = '0;
    rr_mode = 0; bsel_m = 0; gap_next = 0; stall_prev = 0; beat_k = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_read", bus.read, 0);
    chk("rst_bbt", bus.begin_burst_transfer, 0);
    chk("rst_bcount", bus.burst_count, 0);
    chk("rst_addr", bus.address, BASE);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_byte_en", bus.byte_en, 4'hF);
    chk("rst_resp_ready", bus.resp_ready, 1);
    rest = 1'b1;
    repeat (2) @(posedge clk);

    // Frame 1: continuous incrementing pixels, no back-pressure
    rr_mode = 0;
    start_frame();
    drive_pix(100, 1, 2000);
    end_frame(1);

    // Frame 2: random traffic, stray frame_start mid-frame
    rr_mode = 1;
    start_frame();
    fork
      drive_pix(70, 0, 3000);
      begin
        repeat (15) @(posedge clk);
        #1 chk("mid_busy", busy, 1);
        frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
      end
    join
    end_frame(2);

    // Frame 3: slave stalled, FIFO fills and pixels back up
    rr_mode = 2;
    start_frame();
    drive_pix(100, 1, 100);
    chk("stall_pix_count", pix_log.size(), 2 * DEPTH);
    chk("stall_pix_ready", pix_ready, 0);
    chk("stall_write", bus.write, 1);
    rr_mode = 1;
    drive_pix(100, 1, 3000);
    end_frame(3);

    // Frame 4: reset pulled mid-burst
    rr_mode = 1;
    start_frame();
    fork
      drive_pix(100, 0, 3000);
      begin
        int n = 0;
        while (!(bus.write && beat_k >= 3) && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("reach_burst", bus.write, 1);
        #2 rest = 1'b0;
        #1;
        chk("arst_write", bus.write, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pix_ready", pix_ready, 0);
        chk("arst_bbt", bus.begin_burst_transfer, 0);
        chk("arst_bcount", bus.burst_count, 0);
        chk("arst_addr", bus.address, BASE);
        stop_pix = 1;
      end
    join
    bsel_m = 0; gap_next = 0; stall_prev = 0;
    repeat (2) @(posedge clk);
    #1 rest = 1'b1;
    repeat (2) @(posedge clk);

    // Frame 5: fresh frame after reset starts at the base buffer again
    rr_mode = 1;
    start_frame();
    drive_pix(80, 1, 3000);
    end_frame(4);
`ifdef AVL_FRAME_WRITER_PINGPONG_EN
    chk("buf_sel_final", buf_sel, bsel_m);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_frame_writer.md
Name: avl_frame_writer

Overview:
Upstream master of the SDRAM slave on the i_avl_bus. Accepts a 16-bit RGB565 pixel stream from the camera capture path and packs pixels into 32-bit words. Buffers the words in a small FIFO and writes one frame into consecutive SDRAM word addresses using fixed-length write bursts. Sits between the OV5640 capture/format stage and the SDRAM controller (sdram_sim_model in simulation).

Parameters:
FIFO_DEPTH, 16, word FIFO depth; power of two, must be >= BURST_LEN
BURST_LEN, 8, nominal write burst length in words (1..255)
FRAME_WORDS, 153600, 32-bit words per frame (640x480 RGB565 / 2)
BASE_ADDR, 32'h0000_0000, byte address of frame start; word-aligned

Ports:
clk  input  1  system clock
rest  input  1  reset, asynchronous, active-low
frame_start  input  1  one-cycle pulse: begin a new frame; honoured only in IDLE
pix_valid  input  1  pixel valid
pix_data  input  16  RGB565 pixel
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
busy  output  1  high from accepted frame_start until frame_done
frame_done  output  1  one-cycle pulse when the last write beat of the frame is accepted
avl_m0  i_avl_bus.master  -  address[31:0], byte_en[3:0], write, write_data[31:0], read, begin_burst_transfer, burst_count, request_ready, read_data_valid, read_data, resp_ready

Behaviour:
- Clock domain and reset: one clock, clk. rest is asynchronous and active-low.
- Reset values: pix_ready=0, busy=0, frame_done=0, write=0, read=0, begin_burst_transfer=0, burst_count=0, address=BASE_ADDR, write_data=0, byte_en=4'hF. The FIFO, packer and counters are cleared.
- Constant outputs: read is always 0. resp_ready is always 1. byte_en is always 4'hF.
- Packer: the first accepted pixel of a pair goes to word[15:0] and the second to word[31:16]. A word is pushed into the FIFO on the cycle its second pixel is accepted.
- pix_ready: busy && FIFO not full && packed_words < FRAME_WORDS.
  - Pixels beyond 2*FRAME_WORDS are not accepted. pix_ready stays 0 until the next frame.
- States:
  - IDLE: wait for frame_start.
    - On frame_start: word_idx=0, packed_words=0, packer cleared, busy=1, go to WAIT.
  - WAIT: compute beats = min(BURST_LEN, FRAME_WORDS - word_idx).
    - When fifo_count >= beats, go to BURST and present the first beat in the next cycle.
  - BURST: write=1. address = BASE_ADDR + 4*word_idx. write_data = FIFO head. burst_count = beats.
    - begin_burst_transfer=1 on the first beat only.
    - A beat completes on write && request_ready. On completion: pop the FIFO, increment word_idx, advance address by 4.
    - Until request_ready, all bus outputs hold stable.
    - After the last beat of a burst: if word_idx == FRAME_WORDS, go to DONE; otherwise go to WAIT.
  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Throughput: back-to-back beats within a burst are allowed, one per cycle when request_ready=1.
  - Between bursts there is at least one cycle in WAIT with write=0.
- FIFO full: pix_ready=0 and pixels are stalled; none are dropped.
- Simultaneous FIFO push and pop in the same cycle: fifo_count is unchanged.
- Final burst: if FRAME_WORDS is not a multiple of BURST_LEN, the final burst is shorter (burst_count = remainder).
- frame_start while busy: ignored; the current frame continues unaffected.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous). The frame is abandoned and buffered data is discarded.
- Width rules: word_idx and packed_words are $clog2(FRAME_WORDS+1) bits. Address arithmetic is 32-bit with no wrap checking.

Optional Feature:
AVL_FRAME_WRITER_PINGPONG_EN
- Defined:
  - An internal buffer-select bit toggles on each frame_done; it resets to 0.
  - The frame base is BASE_ADDR when the bit is 0, and BASE_ADDR + 4*FRAME_WORDS when it is 1.
  - An extra output port, buf_sel (1 bit), shows the buffer currently being written, or the next one when idle. The downstream reader uses it to read the other buffer.
- Undefined: every frame is written at BASE_ADDR and the buf_sel port does not exist.

Test Plan:
- FRAME_WORDS=16, BURST_LEN=8, request_ready=1, 32 pixels 16'h0001..16'h0020 continuous -> two bursts with burst_count=8, begin_burst_transfer only on beats at addresses 0x00 and 0x20; word 0 = 32'h0002_0001, word 15 = 32'h0020_001F; frame_done one cycle after the last beat.
- FRAME_WORDS=10, BURST_LEN=8 -> bursts of 8 then 2; the final burst starts at address 0x20 with burst_count=2; frame_done pulses once.
- Model run with REQUEST_RANDOM=1 -> address, write_data and burst_count hold stable while request_ready=0; SDRAM contents match a pixel-stream scoreboard for the full frame.
- pix_valid held high with request_ready=0 for 100 cycles, FIFO_DEPTH=16 -> pix_ready drops after 32 pixels; no pixel is lost after request_ready is released.
- frame_start pulsed mid-frame, then rest pulled low mid-burst -> the mid-frame frame_start has no effect; reset returns write=0, busy=0, pix_ready=0 immediately; a new frame_start after reset writes from BASE_ADDR.
- AVL_FRAME_WRITER_PINGPONG_EN, FRAME_WORDS=16, two frames -> frame 1 is written at 0x00..0x3C, frame 2 at 0x40..0x7C; buf_sel reads 0 then 1, and 0 after the second frame_done.
